// File: rtl/dvp_pattern_tx_if.sv
// DVP camera pixel bus: pixel clock, frame sync, line valid and one data byte.
interface dvp_pattern_tx_if;
    logic       pclk_o;
    logic       vsync_o;
    logic       href_o;
    logic [7:0] data_o;

    modport master (output pclk_o, output vsync_o, output href_o, output data_o);
    modport slave  (input  pclk_o, input  vsync_o, input  href_o, input  data_o);
endinterface

// File: rtl/dvp_pattern_tx.sv
// DVP sensor emulator: streams RGB565 test-pattern frames, high byte first, with PCLK = clk/2.
module dvp_pattern_tx #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_BLANK   = 144,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned VS_LINES  = 3,
    parameter int unsigned VBP_LINES = 17,
    parameter int unsigned VFP_LINES = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic [15:0]             solid,
    dvp_pattern_tx_if.master        dvp,
    output logic                    busy,
    output logic                    frame_done,
    output logic [15:0]             frame_cnt
);

    localparam int unsigned LineBytes = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned ActBytes  = 2 * H_ACTIVE;
    localparam int unsigned BarPix    = H_ACTIVE / 8;
    localparam int unsigned MaxA      = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
    localparam int unsigned MaxB      = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
    localparam int unsigned MaxLines  = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned ColW      = $clog2(LineBytes);
    localparam int unsigned LineW     = $clog2(MaxLines + 1);

    typedef enum logic [2:0] {StIdle, StVsync, StVbp, StActive, StVfp} state_e;

    state_e            state_q, state_d;
    logic              pclk_q;
    logic [ColW-1:0]   col_q, col_d;
    logic [LineW-1:0]  line_q, line_d, last_line;
    logic [2:0]        bar_q, bar_d;
    logic [ColW-1:0]   bar_pix_q, bar_pix_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       solid_q, solid_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              done_q, done_d;
    logic              drive, line_end, phase_end, start_frame, in_href;
    logic [15:0]       x16, pix;

    // Everything but pclk advances only on the clk edge where PCLK falls.
    assign drive   = pclk_q;
    assign in_href = (state_q == StActive) && (col_q < ColW'(ActBytes));

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_q      <= 1'b0;
            state_q     <= StIdle;
            col_q       <= '0;
            line_q      <= '0;
            bar_q       <= '0;
            bar_pix_q   <= '0;
            mode_q      <= '0;
            solid_q     <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            pclk_q      <= ~pclk_q;
            state_q     <= state_d;
            col_q       <= col_d;
            line_q      <= line_d;
            bar_q       <= bar_d;
            bar_pix_q   <= bar_pix_d;
            mode_q      <= mode_d;
            solid_q     <= solid_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        last_line = LineW'(VFP_LINES - 1);
        case (state_q)
            StVsync:  last_line = LineW'(VS_LINES - 1);
            StVbp:    last_line = LineW'(VBP_LINES - 1);
            StActive: last_line = LineW'(V_ACTIVE - 1);
            default:  last_line = LineW'(VFP_LINES - 1);
        endcase
    end

    assign line_end  = (col_q == ColW'(LineBytes - 1));
    assign phase_end = line_end && (line_q == last_line);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        bar_d       = bar_q;
        bar_pix_d   = bar_pix_q;
        mode_d      = mode_q;
        solid_d     = solid_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        start_frame = 1'b0;

        if (drive) begin
            if (state_q == StIdle) begin
                start_frame = en;
            end else begin
                col_d = line_end ? '0 : col_q + ColW'(1);
                // Bar position steps after the low byte of each pixel.
                if (in_href && col_q[0]) begin
                    if (bar_pix_q == ColW'(BarPix - 1)) begin
                        bar_pix_d = '0;
                        bar_d     = bar_q + 3'd1;
                    end else begin
                        bar_pix_d = bar_pix_q + ColW'(1);
                    end
                end
                if (line_end) begin
                    bar_d     = '0;
                    bar_pix_d = '0;
                    line_d    = line_q + LineW'(1);
                    if (phase_end) begin
                        line_d = '0;
                        case (state_q)
                            StVsync:  state_d = StVbp;
                            StVbp:    state_d = StActive;
                            StActive: state_d = StVfp;
                            StVfp: begin
                                done_d      = 1'b1;
                                frame_cnt_d = frame_cnt_q + 16'd1;
                                start_frame = en;
                                state_d     = StIdle;
                            end
                            default:  state_d = StIdle;
                        endcase
                    end
                end
            end
            if (start_frame) begin
                state_d   = StVsync;
                col_d     = '0;
                line_d    = '0;
                bar_d     = '0;
                bar_pix_d = '0;
                mode_d    = mode;
                solid_d   = solid;
            end
        end
    end

    assign x16 = 16'(col_q >> 1);

    always_comb begin
        pix = 16'h0000;
        case (mode_q)
            2'd0: begin
                case (bar_q)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd1:    pix = x16;
            2'd2:    pix = {16{(|((x16 ^ 16'(line_q)) & 16'h0008)) ^ frame_cnt_q[0]}};
            default: pix = solid_q;
        endcase
    end

    assign dvp.pclk_o  = pclk_q;
    assign dvp.vsync_o = (state_q == StVsync);
    assign dvp.href_o  = in_href;
    assign dvp.data_o  = in_href ? (col_q[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    assign busy        = (state_q != StIdle);
    assign frame_done  = done_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Scoreboard bench for dvp_pattern_tx: expected frame bytes and frame_done events are queued
// by the stimulus and consumed by an independent monitor.
module tb_dvp_pattern_tx;
    localparam int HA = 16, HB = 4, VA = 4, VS = 1, VBP = 1, VFP = 1;
    localparam int L = 2 * HA + HB;
    localparam int FRAME_CLK = 2 * L * (VS + VBP + VA + VFP);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid = 16'h0000;
    logic        busy, frame_done;
    logic [15:0] frame_cnt;

    dvp_pattern_tx_if dvp ();

    dvp_pattern_tx #(
        .H_ACTIVE (HA), .H_BLANK (HB), .V_ACTIVE (VA),
        .VS_LINES (VS), .VBP_LINES (VBP), .VFP_LINES (VFP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .solid      (solid),
        .dvp        (dvp),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // clk edges since reset release; odd values fall mid byte period
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {int t; int cnt;} frame_exp_t;
    frame_exp_t fq[$];
    logic [7:0] bq[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    endtask

    task automatic summary();
        $display("%0d/%0d checks passed", n_pass, n_checks);
    endtask

    function automatic logic [15:0] model_pix(input int m, input logic [15:0] s,
                                              input int x, input int y, input int fc);
        logic [15:0] bars [8];
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        case (m)
            0:       return bars[x / (HA / 8)];
            1:       return 16'(x);
            2:       return (((x / 8) + (y / 8) + fc) % 2 == 1) ? 16'hFFFF : 16'h0000;
            default: return s;
        endcase
    endfunction

    task automatic push_frame(input int m, input logic [15:0] s, input int fc, input int start);
        logic [15:0] p;
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
                p = model_pix(m, s, x, y, fc);
                bq.push_back(p[15:8]);
                bq.push_back(p[7:0]);
            end
        end
        fq.push_back('{start + FRAME_CLK, (fc + 1) % 65536});
    endtask

    task automatic at_cyc(input int c);
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc == c) break;
            n++;
            if (n > 200000) begin
                n_checks++;
                $display("FAIL at_cyc: timed out at cyc %0d, required cyc %0d", cyc, c);
                summary();
                $finish;
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_vsync"}, dvp.vsync_o, 0);
        check({tag, "_href"},  dvp.href_o, 0);
        check({tag, "_data"},  dvp.data_o, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  frame_done, 0);
    endtask

    // Monitor: pclk phase, byte stream on href, line/frame timing, frame_done events.
    initial begin
        int vs_len, hr_len, vbp_len;
        bit vs_prev, hr_prev, vbp_arm, done_prev;
        frame_exp_t e;
        vs_len = 0; hr_len = 0; vbp_len = 0;
        vs_prev = 0; hr_prev = 0; vbp_arm = 0; done_prev = 0;
        forever begin
            @(posedge clk);
            #1;
            check("pclk", dvp.pclk_o, cyc % 2);
            if (frame_done) begin
                check("done_width", done_prev, 0);
                check("done_expected", fq.size() != 0, 1);
                if (fq.size() != 0) begin
                    e = fq.pop_front();
                    check("done_time", cyc, e.t);
                    check("frame_cnt", frame_cnt, e.cnt);
                    check("bytes_left", bq.size(), 0);
                end
            end
            done_prev = frame_done;
            if (cyc == 0) begin
                vs_len = 0; hr_len = 0; vbp_len = 0;
                vs_prev = 0; hr_prev = 0; vbp_arm = 0;
            end else if (cyc % 2 == 1) begin
                if (dvp.href_o) begin
                    check("byte_expected", bq.size() != 0, 1);
                    if (bq.size() != 0) check("data", dvp.data_o, bq.pop_front());
                    hr_len++;
                end else begin
                    check("data_idle", dvp.data_o, 0);
                    if (hr_prev) check("href_width", hr_len, 2 * HA);
                    hr_len = 0;
                end
                if (dvp.vsync_o) begin
                    vs_len++;
                end else begin
                    if (vs_prev) begin
                        check("vsync_width", vs_len, VS * L);
                        vbp_arm = 1;
                        vbp_len = 0;
                    end
                    vs_len = 0;
                end
                if (vbp_arm && !dvp.vsync_o) begin
                    if (dvp.href_o) begin
                        check("vbp_gap", vbp_len, VBP * L);
                        vbp_arm = 0;
                    end else begin
                        vbp_len++;
                    end
                end
                vs_prev = dvp.vsync_o;
                hr_prev = dvp.href_o;
            end
        end
    end

    initial begin
        #2000000;
        n_checks++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $finish;
    end

    // Stimulus
    initial begin
        int s, s7;
        int fm [7];
        logic [15:0] fs [7];

        fm = '{0, 2, 2, 1, 3, 0, 0};
        for (int i = 0; i < 7; i++) fs[i] = 16'($urandom);
        fs[4] = 16'hABCD;
        fm[5] = int'($urandom_range(0, 3));
        fm[6] = int'($urandom_range(0, 3));

        repeat (3) @(posedge clk);
        #1;
        check("rst_pclk", dvp.pclk_o, 0);
        check_quiet("rst");
        check("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;

        at_cyc(10);
        check_quiet("idle");

        s = 22;
        at_cyc(s - 2);
        mode  = 2'(fm[0]);
        solid = fs[0];
        en    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            at_cyc(s + 2);
            push_frame(fm[i], fs[i], i, s);
            at_cyc(s + 250);
            if (i < 6) begin
                mode  = 2'(fm[i + 1]);
                solid = fs[i + 1];
            end else begin
                en    = 1'b0;
                mode  = 2'($urandom_range(0, 3));
                solid = 16'($urandom);
            end
            s += FRAME_CLK;
        end

        at_cyc(s + 20);
        check_quiet("stopped");
        check("stopped_frame_cnt", frame_cnt, 7);
        check("frames_pending", fq.size(), 0);
        check("bytes_pending", bq.size(), 0);

        at_cyc(s + 200);
        mode = 2'd2;
        en   = 1'b1;
        s7   = s + 202;
        at_cyc(s7 + 2);
        push_frame(2, 16'h0000, 7, s7);
        at_cyc(s7 + 284);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        check("abort_pclk", dvp.pclk_o, 0);
        check_quiet("abort");
        check("abort_frame_cnt", frame_cnt, 0);
        bq.delete();
        fq.delete();
        rst = 1'b0;

        at_cyc(600);
        check_quiet("after_abort");
        check("after_abort_frame_cnt", frame_cnt, 0);

        summary();
        $finish;
    end
endmodule
